// File: rtl/div_clock_ctrl_pkg.sv
// Shared types for the PWM clock-divider blocks: on/off state, controller FSM
// states and the default divider width.
package div_clock_ctrl_pkg;
  localparam int PWM_DIV_W = 5;

  typedef enum logic {PWM_OFF = 1'b0, PWM_ON = 1'b1} pwm_onoff_t;

  typedef enum logic [1:0] {
    DIVCTL_OFF,
    DIVCTL_RUN,
    DIVCTL_WAIT_EDGE
  } divctl_state_t;
endpackage

// File: rtl/div_clk_edge_det.sv
// Falling-edge detector on the divided clock fed back from the divider.
module div_clk_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic div_clk,
  output logic fall
);
  logic div_clk_q;

  always_ff @(posedge clk) begin
    if (reset) div_clk_q <= 1'b0;
    else       div_clk_q <= div_clk;
  end

  assign fall = div_clk_q & ~div_clk;
endmodule

// File: rtl/div_clock_ctrl.sv
// Run-time controller for the PWM clock divider: accepts start/stop/divider
// requests and applies them on a div_clk falling edge so no runt phase appears.
module div_clock_ctrl
  import div_clock_ctrl_pkg::*;
#(
  parameter int               DIV_W       = PWM_DIV_W,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = '0,
  parameter int               TIMEOUT_CYC = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_divider,
  input  logic             cfg_enable,
  input  logic             div_clk,
  output logic [DIV_W-1:0] divider,
  output pwm_onoff_t       pwm_onoff,
  output logic             busy,
  output logic             update_done,
  output logic             timeout_err
);
  localparam int              CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  // The timeout must outlast the slowest divided-clock period.
  if (TIMEOUT_CYC <= 2 * (2 ** DIV_W)) begin : g_bad_timeout
    $error("div_clock_ctrl: TIMEOUT_CYC must exceed 2*(2^DIV_W)");
  end

  divctl_state_t    state, state_nxt;
  logic [DIV_W-1:0] pend_div;
  logic             pend_en;
  logic [CNT_W-1:0] cnt;
  logic             fall, accept, noop, tmo, upd;

  div_clk_edge_det u_edge (
    .clk     (clk),
    .reset   (reset),
    .div_clk (div_clk),
    .fall    (fall)
  );

  assign cfg_ready = (state != DIVCTL_WAIT_EDGE);
  assign busy      = (state == DIVCTL_WAIT_EDGE);
  assign accept    = cfg_valid & cfg_ready;
  assign noop      = cfg_enable && (cfg_divider == divider);
  assign tmo       = (cnt == CNT_LAST);
  assign upd       = busy && (fall || tmo);

  always_ff @(posedge clk) begin
    if (reset) state <= DIVCTL_OFF;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIVCTL_OFF:       if (accept) state_nxt = cfg_enable ? DIVCTL_RUN : DIVCTL_OFF;
      DIVCTL_RUN:       if (accept && !noop) state_nxt = DIVCTL_WAIT_EDGE;
      DIVCTL_WAIT_EDGE: if (upd) state_nxt = pend_en ? DIVCTL_RUN : DIVCTL_OFF;
      default:          state_nxt = DIVCTL_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      divider     <= DEFAULT_DIV;
      pwm_onoff   <= PWM_OFF;
      pend_div    <= '0;
      pend_en     <= 1'b0;
      cnt         <= '0;
      update_done <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      update_done <= 1'b0;
      if (accept) timeout_err <= 1'b0;
      case (state)
        // Divider is held in reset while off, so changes apply immediately.
        DIVCTL_OFF: if (accept) begin
          divider     <= cfg_divider;
          pwm_onoff   <= cfg_enable ? PWM_ON : PWM_OFF;
          update_done <= 1'b1;
        end
        DIVCTL_RUN: if (accept) begin
          if (noop) update_done <= 1'b1;
          else begin
            pend_div <= cfg_divider;
            pend_en  <= cfg_enable;
            cnt      <= '0;
          end
        end
        DIVCTL_WAIT_EDGE: begin
          if (upd) begin
            divider     <= pend_div;
            if (!pend_en) pwm_onoff <= PWM_OFF;
            update_done <= 1'b1;
            if (!fall) timeout_err <= 1'b1;
          end else if (!tmo) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_clock_ctrl.sv
// Bench for div_clock_ctrl: directed scenarios plus randomized requests, checked
// every cycle against a cycle-count based behavioural model.
module tb_div_clock_ctrl;
  import div_clock_ctrl_pkg::*;

  localparam int DIV_W = 5;
  localparam int TMO   = 128;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_enable = 1'b0;
  logic [DIV_W-1:0] cfg_divider = '0;
  logic             div_clk = 1'b0;
  logic             cfg_ready, busy, update_done, timeout_err;
  logic [DIV_W-1:0] divider;
  pwm_onoff_t       pwm_onoff;

  int checks = 0, failures = 0;
  bit force_hi = 0, chk_en = 0;
  int dcnt = 0;

  always #5 clk = ~clk;

  div_clock_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_divider (cfg_divider),
    .cfg_enable  (cfg_enable),
    .div_clk     (div_clk),
    .divider     (divider),
    .pwm_onoff   (pwm_onoff),
    .busy        (busy),
    .update_done (update_done),
    .timeout_err (timeout_err)
  );

  // Stand-in for the PWM divider: half period of divider+1 clk, held low when off.
  always @(negedge clk) begin
    if (force_hi) div_clk = 1'b1;
    else if (pwm_onoff != PWM_ON) begin dcnt = 0; div_clk = 1'b0; end
    else if (dcnt >= int'(divider)) begin dcnt = 0; div_clk = ~div_clk; end
    else dcnt++;
  end

  // Behavioural model: mode 0=off 1=run 2=waiting; timeout via absolute deadline.
  int               m_mode = 0, cyc = 0, m_deadline = 0;
  logic [DIV_W-1:0] m_div = '0, m_pd = '0;
  bit               m_on = 0, m_pe = 0, m_done = 0, m_terr = 0, m_prev = 0;

  always @(posedge clk) begin
    bit fall_s, rdy;
    cyc++;
    fall_s = m_prev && !div_clk;
    rdy    = (m_mode != 2);
    m_done = 0;
    if (reset) begin
      m_mode = 0; m_div = '0; m_on = 0; m_terr = 0; m_prev = 0; chk_en = 1;
    end else begin
      if (cfg_valid && rdy) m_terr = 0;
      if (m_mode == 0 && cfg_valid) begin
        m_div = cfg_divider; m_on = cfg_enable; m_done = 1;
        m_mode = cfg_enable ? 1 : 0;
      end else if (m_mode == 1 && cfg_valid) begin
        if (cfg_enable && cfg_divider == m_div) m_done = 1;
        else begin
          m_pd = cfg_divider; m_pe = cfg_enable; m_deadline = cyc + TMO; m_mode = 2;
        end
      end else if (m_mode == 2 && (fall_s || cyc == m_deadline)) begin
        m_div = m_pd;
        if (!m_pe) m_on = 0;
        m_done = 1;
        if (!fall_s) m_terr = 1;
        m_mode = m_pe ? 1 : 0;
      end
      m_prev = div_clk;
    end
  end

  always begin
    @(posedge clk); #1;
    if (chk_en) begin
      checks++;
      if (divider !== m_div || pwm_onoff !== pwm_onoff_t'(m_on) || busy !== (m_mode == 2) ||
          cfg_ready !== (m_mode != 2) || update_done !== m_done || timeout_err !== m_terr) begin
        failures++;
        $display("FAIL model cyc=%0d got div=%0d on=%0d busy=%b rdy=%b done=%b terr=%b exp div=%0d on=%0d busy=%b rdy=%b done=%b terr=%b",
                 cyc, divider, pwm_onoff, busy, cfg_ready, update_done, timeout_err,
                 m_div, m_on, m_mode == 2, m_mode != 2, m_done, m_terr);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Issue one request and return on the negedge after it was accepted.
  task automatic req(input logic [DIV_W-1:0] d, input logic e);
    int n = 0;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_divider = d; cfg_enable = e;
    while (cfg_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) chk("req_ready_timeout", 32'(n), 32'd0);
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk(name, 32'(n), 32'd0);
  endtask

  task automatic rnd_req();
    cfg_valid   = 1'b1;
    cfg_divider = ($urandom_range(0, 7) == 0) ? DIV_W'($urandom_range(0, 31))
                                              : DIV_W'($urandom_range(0, 3));
    cfg_enable  = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    int n;
    bit acc_last;
    repeat (3) @(negedge clk);
    chk("rst_divider", divider, 0);
    chk("rst_onoff", pwm_onoff, PWM_OFF);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", update_done, 0);
    chk("rst_terr", timeout_err, 0);
    reset = 1'b0;

    // Start from OFF: one-cycle latency.
    req(5'd3, 1'b1);
    chk("start_div", divider, 3);
    chk("start_on", pwm_onoff, PWM_ON);
    chk("start_done", update_done, 1);
    @(negedge clk);
    chk("start_done_1cyc", update_done, 0);
    n = 0;
    while (div_clk !== 1'b1 && n < 50) begin @(posedge clk); n++; end
    n = 0;
    while (div_clk === 1'b1 && n < 50) begin n++; @(posedge clk); end
    chk("div3_high_phase", 32'(n), 32'd4);

    // Change divider while running: waits for a falling edge.
    req(5'd7, 1'b1);
    chk("chg_busy", busy, 1);
    chk("chg_ready", cfg_ready, 0);
    wait_idle("chg_wait_bound");
    chk("chg_div", divider, 7);
    chk("chg_done", update_done, 1);

    // Same divider while running: no-op shortcut.
    req(5'd7, 1'b1);
    chk("noop_done", update_done, 1);
    chk("noop_busy", busy, 0);

    // div_clk stuck high: forced update after the timeout.
    force_hi = 1;
    repeat (3) @(negedge clk);
    req(5'd2, 1'b1);
    n = 0;
    while (busy === 1'b1 && n < 300) begin n++; @(negedge clk); end
    chk("tmo_busy_cycles", 32'(n), 32'd128);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_div", divider, 2);
    chk("tmo_done", update_done, 1);
    force_hi = 0;
    req(5'd4, 1'b1);
    chk("tmo_err_clear", timeout_err, 0);
    wait_idle("clr_wait_bound");

    // Reset while waiting discards the request.
    force_hi = 1;
    repeat (3) @(negedge clk);
    req(5'd5, 1'b1);
    chk("rstw_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rstw_div", divider, 0);
    chk("rstw_onoff", pwm_onoff, PWM_OFF);
    chk("rstw_busy0", busy, 0);
    chk("rstw_done", update_done, 0);
    reset = 1'b0;
    force_hi = 0;

    // Disable while running: turns off on a falling edge, div_clk stays low.
    req(5'd3, 1'b1);
    req(5'd3, 1'b0);
    chk("off_busy", busy, 1);
    wait_idle("off_wait_bound");
    chk("off_onoff", pwm_onoff, PWM_OFF);
    repeat (6) @(posedge clk);
    chk("off_divclk_low", div_clk, 0);

    // Randomized traffic, reset and stuck-high windows.
    acc_last = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 149) == 0) force_hi = !force_hi;
      if (cfg_valid && acc_last) begin
        if ($urandom_range(0, 1) == 0) cfg_valid = 1'b0;
        else rnd_req();
      end else if (!cfg_valid && $urandom_range(0, 3) == 0) begin
        rnd_req();
      end
      acc_last = cfg_valid && cfg_ready && !reset;
    end
    @(negedge clk);
    reset = 1'b0; cfg_valid = 1'b0; force_hi = 0;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/div_clock_ctrl.md
Name: div_clock_ctrl

Overview:
- Run-time controller for the PWM clock divider.
- Accepts start, stop and divider-change requests over a valid/ready handshake.
- Drives the divider's `divider` and `pwm_onoff` inputs and monitors its `div_clk` output.
- Applies changes only on a falling edge of `div_clk`, so no runt or over-long divided-clock phase is produced. Sits between the register interface and the divider.

Parameters:
- DIV_W, 5, width of divider value.
- DEFAULT_DIV, 5'd0, divider value driven after reset.
- TIMEOUT_CYC, 128, clk cycles to wait for a `div_clk` falling edge before forcing the update. Must be greater than 2*(2^DIV_W); checked by elaboration assertion.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous, active-high.
- cfg_valid, in, 1, request valid.
- cfg_ready, out, 1, controller can accept a request.
- cfg_divider, in, DIV_W, requested divider value.
- cfg_enable, in, 1, requested state: 1 = PWM_ON, 0 = PWM_OFF.
- div_clk, in, 1, divided clock fed back from the divider.
- divider, out, DIV_W, applied divider value.
- pwm_onoff, out, _pwm_onoff, applied on/off state.
- busy, out, 1, update pending (state WAIT_EDGE).
- update_done, out, 1, one-cycle pulse when a request has been applied.
- timeout_err, out, 1, sticky; last update was forced by timeout.

Behaviour:
- Single clock domain. Reset is synchronous and active-high; all state changes occur on posedge clk.
- Reset values:
  - state OFF, divider=DEFAULT_DIV, pwm_onoff=PWM_OFF.
  - cfg_ready=1, busy=0, update_done=0, timeout_err=0.
  - pending registers and timeout counter = 0.
  - div_clk history register = 0.
- Reset asserted in any state, including WAIT_EDGE, discards the pending request. No update_done is issued.
- Handshake:
  - Accept when cfg_valid && cfg_ready. cfg_ready = 1 in OFF and RUN, 0 in WAIT_EDGE.
  - cfg_divider and cfg_enable are captured on the accepting edge.
  - Acceptance clears timeout_err.
  - The requester holds cfg_valid and data stable until accepted.
- Falling edge detection: div_clk_q <= div_clk each cycle. fall = div_clk_q & ~div_clk.
- State OFF (divider held in reset by PWM_OFF), on accept:
  - divider <= cfg_divider.
  - pwm_onoff <= PWM_ON if cfg_enable, else PWM_OFF.
  - update_done pulses the next cycle.
  - Next state is RUN if cfg_enable, else OFF.
  - Latency is 1 cycle; no edge wait.
- State RUN, on accept:
  - Shortcut: if cfg_enable=1 and cfg_divider==divider, the request is a no-op. update_done pulses the next cycle and the state stays RUN.
  - Otherwise go to WAIT_EDGE and clear the timeout counter.
- State WAIT_EDGE:
  - The timeout counter increments every cycle.
  - Update condition: fall, or counter==TIMEOUT_CYC-1.
  - On that cycle's edge: divider <= pending divider; pwm_onoff <= PWM_OFF if pending enable=0.
  - update_done pulses for one cycle.
  - Next state is OFF if pending enable=0, else RUN.
  - If the update was forced by timeout and fall was not present, timeout_err <= 1.
  - fall and timeout in the same cycle count as a normal update; timeout_err stays 0.
  - Outputs are visible the cycle after `div_clk` is first sampled low following a high sample.
- Width rules:
  - Timeout counter width is $clog2(TIMEOUT_CYC).
  - Counter saturates; it never wraps.
  - The divider compare is an unsigned DIV_W-bit equality.
- busy = (state==WAIT_EDGE). update_done is never asserted for two consecutive cycles from a single request.
- Back-to-back requests: a new request can be accepted on the cycle update_done is high, since cfg_ready is already 1 in OFF/RUN.

Decomposition:
- PKG_pwm gains:
  - typedef enum _divctl_state {DIVCTL_OFF, DIVCTL_RUN, DIVCTL_WAIT_EDGE}.
  - localparam PWM_DIV_W = 5.
- Reuse the existing _pwm_onoff type.
- One sub-module: div_clk_edge_det. It contains the history register and the fall output, and is reused by later PWM blocks.

Test Plan:
- Reset then request {div=3, en=1} in OFF -> 1 cycle later divider=3, pwm_onoff=PWM_ON, update_done=1 for 1 cycle; `div_clk` toggles every 4 clk.
- In RUN with div=3, request {div=7, en=1} -> busy=1, cfg_ready=0; divider changes to 7 exactly 1 cycle after `div_clk` first samples low; update_done pulses; no `div_clk` high phase shorter than 4 clk.
- In RUN, request {div=3, en=0} -> pwm_onoff=PWM_OFF only after a `div_clk` falling edge; state OFF; `div_clk` stays 0.
- In RUN, request {div=3, en=1} (same as current) -> update_done after 1 cycle; busy never asserted.
- Hold `div_clk` high externally in WAIT_EDGE -> update forced after 128 cycles, timeout_err=1; next accepted request clears it.
- Assert reset during WAIT_EDGE -> next cycle divider=DEFAULT_DIV, pwm_onoff=PWM_OFF, busy=0, no update_done.
